// File: rtl/dmg_timer_pkg.sv
// rtl/dmg_timer_pkg.sv - shared encodings and constants for the DMG timer block.
package dmg_timer_pkg;

  typedef enum logic [1:0] {
    SEL_DIV  = 2'd0,
    SEL_TIMA = 2'd1,
    SEL_TMA  = 2'd2,
    SEL_TAC  = 2'd3
  } sel_t;

  localparam int TAC_EN_BIT   = 2;
  localparam int TAC_TAP_MSB  = 1;
  localparam int TAC_TAP_LSB  = 0;

  localparam logic [7:0] TAC_READ_MASK = 8'hF8;
  localparam int         OVF_DELAY     = 4;

  // Divider bit that feeds the timer for each TAC[1:0] setting.
  function automatic logic [3:0] tap_bit(input logic [1:0] tap_sel);
    case (tap_sel)
      2'b00:   tap_bit = 4'd9;
      2'b01:   tap_bit = 4'd3;
      2'b10:   tap_bit = 4'd5;
      default: tap_bit = 4'd7;
    endcase
  endfunction

endpackage

// File: rtl/dmg_timer_edge.sv
// rtl/dmg_timer_edge.sv - falling-edge detector on the timer tick, sampled per ce cycle.
module dmg_timer_edge (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic tick,
  output logic fall
);

  logic hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 1'b0;
    end else if (ce) begin
      hist <= tick;
    end
  end

  assign fall = ce & hist & ~tick;

endmodule

// File: rtl/dmg_timer.sv
// rtl/dmg_timer.sv - DIV/TIMA/TMA/TAC timer; TIMER_OVF_DELAY_EN enables the 4-cycle reload delay.
module dmg_timer
  import dmg_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] sel,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq
);

  logic [15:0] counter;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic        tick;
  logic        fall;
  logic        wr_div, wr_tima, wr_tma, wr_tac;
  logic [7:0]  tma_next;

  assign wr_div  = ce & wr & (sel == SEL_DIV);
  assign wr_tima = ce & wr & (sel == SEL_TIMA);
  assign wr_tma  = ce & wr & (sel == SEL_TMA);
  assign wr_tac  = ce & wr & (sel == SEL_TAC);

  // A reload coinciding with a TMA write picks up the value being written.
  assign tma_next = wr_tma ? din : tma;

  assign tick = tac[TAC_EN_BIT] & counter[tap_bit(tac[TAC_TAP_MSB:TAC_TAP_LSB])];

  dmg_timer_edge u_edge (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .tick  (tick),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= 16'h0000;
      tma     <= 8'h00;
      tac     <= 3'b000;
    end else if (ce) begin
      counter <= wr_div ? 16'h0000 : counter + 16'h0001;
      if (wr_tma) tma <= din;
      if (wr_tac) tac <= din[2:0];
    end
  end

`ifdef TIMER_OVF_DELAY_EN
  logic [2:0] dly;

  // dly counts down the ce cycles left before the pending reload lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      tima <= 8'h00;
      dly  <= 3'd0;
      irq  <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (ce) begin
        if (wr_tima) begin
          tima <= din;
          dly  <= 3'd0;
        end else if (dly == 3'd1) begin
          tima <= tma_next;
          irq  <= 1'b1;
          dly  <= 3'd0;
        end else begin
          if (dly != 3'd0) dly <= dly - 3'd1;
          if (fall) begin
            if (tima == 8'hFF) begin
              tima <= 8'h00;
              dly  <= 3'(OVF_DELAY);
            end else begin
              tima <= tima + 8'h01;
            end
          end
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      tima <= 8'h00;
      irq  <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (ce) begin
        if (wr_tima) begin
          tima <= din;
        end else if (fall) begin
          if (tima == 8'hFF) begin
            tima <= tma_next;
            irq  <= 1'b1;
          end else begin
            tima <= tima + 8'h01;
          end
        end
      end
    end
  end
`endif

  always_comb begin
    dout = 8'h00;
    case (sel)
      SEL_DIV:  dout = counter[15:8];
      SEL_TIMA: dout = tima;
      SEL_TMA:  dout = tma;
      default:  dout = TAC_READ_MASK | {5'b00000, tac};
    endcase
  end

endmodule

// File: tb/tb_dmg_timer.sv
// tb/tb_dmg_timer.sv - randomized and scenario bench for dmg_timer against a behavioural model.
module tb_dmg_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

`ifdef TIMER_OVF_DELAY_EN
  localparam bit DELAY_EN = 1'b1;
`else
  localparam bit DELAY_EN = 1'b0;
`endif
  localparam int OVF_WAIT = 4;

  int   m_cnt;
  int   m_tima, m_tma, m_tac;
  bit   m_prev;
  bit   m_irq;
  int   m_ce_n;
  int   m_reload_at;
  int   taps [4] = '{9, 3, 5, 7};

  dmg_timer dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .sel   (sel),
    .wr    (wr),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  function automatic int model_read(input int s);
    case (s)
      0:       return (m_cnt >> 8) & 255;
      1:       return m_tima;
      2:       return m_tma;
      default: return 248 | m_tac;
    endcase
  endfunction

  // Reload is scheduled as an absolute ce-cycle index rather than a countdown.
  task automatic model_clock(input bit r, input bit c, input int s, input bit w, input int d);
    bit tick_now, fell;
    int tma_new;
    if (r) begin
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0;
      m_prev = 0; m_irq = 0; m_ce_n = 0; m_reload_at = -1;
      return;
    end
    m_irq = 0;
    if (!c) return;
    m_ce_n++;
    tick_now = ((m_tac >> 2) & 1) == 1 && ((m_cnt >> taps[m_tac & 3]) & 1) == 1;
    fell = m_prev && !tick_now;
    m_prev = tick_now;
    tma_new = (w && s == 2) ? d : m_tma;
    if (w && s == 1) begin
      m_tima = d;
      m_reload_at = -1;
    end else if (m_reload_at == m_ce_n) begin
      m_tima = tma_new;
      m_irq = 1;
      m_reload_at = -1;
    end else if (fell) begin
      if (m_tima == 255) begin
        if (DELAY_EN) begin
          m_tima = 0;
          m_reload_at = m_ce_n + OVF_WAIT;
        end else begin
          m_tima = tma_new;
          m_irq = 1;
        end
      end else begin
        m_tima = m_tima + 1;
      end
    end
    m_cnt = (w && s == 0) ? 0 : ((m_cnt + 1) % 65536);
    if (w && s == 3) m_tac = d & 7;
    m_tma = tma_new;
  endtask

  task automatic step(input bit r, input bit c, input logic [1:0] s, input bit w, input logic [7:0] d);
    #1;
    reset = r; ce = c; sel = s; wr = w; din = d;
    @(posedge clk);
    model_clock(r, c, int'(s), w, int'(d));
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      n_tests++;
      if (dout !== 8'(model_read(int'(sel)))) begin
        n_fail++;
        $display("FAIL model_dout sel=%0d: got %02h, expected %02h", sel, dout, 8'(model_read(int'(sel))));
      end
      n_tests++;
      if (irq !== m_irq) begin
        n_fail++;
        $display("FAIL model_irq: got %0b, expected %0b", irq, m_irq);
      end
    end
  end

  int irq_seen;
  logic [7:0] dv;

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_on = 1'b1;

    step(0, 0, 2'd0, 0, 0); #2 chk("reset_div",  dout, 8'h00);
    step(0, 0, 2'd1, 0, 0); #2 chk("reset_tima", dout, 8'h00);
    step(0, 0, 2'd2, 0, 0); #2 chk("reset_tma",  dout, 8'h00);
    step(0, 0, 2'd3, 0, 0); #2 chk("reset_tac",  dout, 8'hF8);
    chk("reset_irq", {7'b0, irq}, 8'h00);

    for (int i = 0; i < 256; i++) step(0, 1, 2'd0, 0, 0);
    #2 chk("div_256", dout, 8'h01);
    step(0, 1, 2'd0, 1, 8'h5A);
    #2 chk("div_clear", dout, 8'h00);

    step(1, 0, 0, 0, 0);
    step(0, 1, 2'd3, 1, 8'h05);
    step(0, 1, 2'd1, 1, 8'h00);
    irq_seen = 0;
    for (int i = 0; i < 160; i++) begin
      step(0, 1, 2'd1, 0, 0);
      #2 if (irq) irq_seen++;
    end
    chk("tima_160", dout, 8'h0A);
    chk("no_irq_160", 8'(irq_seen), 8'h00);

    step(1, 0, 0, 0, 0);
    step(0, 1, 2'd2, 1, 8'hC0);
    step(0, 1, 2'd3, 1, 8'h05);
    step(0, 1, 2'd1, 1, 8'hFF);
    for (int i = 0; i < 14; i++) step(0, 1, 2'd1, 0, 0);
`ifdef TIMER_OVF_DELAY_EN
    #2 chk("ovf_zero_0", dout, 8'h00);
    chk("ovf_noirq_0", {7'b0, irq}, 8'h00);
    for (int i = 1; i < 4; i++) begin
      step(0, 1, 2'd1, 0, 0);
      #2 chk("ovf_zero", dout, 8'h00);
      chk("ovf_noirq", {7'b0, irq}, 8'h00);
    end
    step(0, 1, 2'd1, 0, 0);
    #2 chk("ovf_reload", dout, 8'hC0);
    chk("ovf_irq", {7'b0, irq}, 8'h01);
    step(0, 1, 2'd1, 0, 0);
    #2 chk("ovf_irq_done", {7'b0, irq}, 8'h00);

    step(0, 1, 2'd1, 1, 8'hFF);
    for (int i = 0; i < 15; i++) step(0, 1, 2'd1, 0, 0);
    #2 chk("ovf2_zero", dout, 8'h00);
    step(0, 1, 2'd1, 0, 0);
    step(0, 1, 2'd1, 1, 8'h33);
    irq_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 2'd1, 0, 0);
      #2 if (irq) irq_seen++;
    end
    chk("cancel_tima", dout, 8'h33);
    chk("cancel_noirq", 8'(irq_seen), 8'h00);
`else
    #2 chk("ovf_reload", dout, 8'hC0);
    chk("ovf_irq", {7'b0, irq}, 8'h01);
    step(0, 1, 2'd1, 0, 0);
    #2 chk("ovf_irq_done", {7'b0, irq}, 8'h00);
    chk("ovf_hold", dout, 8'hC0);
`endif

    step(1, 0, 0, 0, 0);
    step(0, 1, 2'd3, 1, 8'h05);
    for (int i = 0; i < 8; i++) step(0, 1, 2'd1, 0, 0);
    step(0, 1, 2'd0, 1, 8'h00);
    step(0, 1, 2'd1, 0, 0);
    #2 chk("div_wr_fall", dout, 8'h01);
    for (int i = 0; i < 8; i++) step(0, 1, 2'd1, 0, 0);
    step(0, 1, 2'd3, 1, 8'h01);
    step(0, 1, 2'd1, 0, 0);
    #2 chk("tac_wr_fall", dout, 8'h02);

    step(0, 1, 2'd2, 1, 8'h77);
    step(0, 1, 2'd3, 1, 8'h05);
    step(0, 1, 2'd1, 1, 8'hFF);
    for (int i = 0; i < 16; i++) step(0, 1, 2'd1, 0, 0);
    step(1, 0, 2'd1, 0, 0);
    irq_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 2'(i % 4), 0, 0);
      #2 if (irq) irq_seen++;
    end
    chk("rst_mid_irq", 8'(irq_seen), 8'h00);
    step(0, 0, 2'd0, 0, 0); #2 chk("rst_mid_div",  dout, 8'h00);
    step(0, 0, 2'd1, 0, 0); #2 chk("rst_mid_tima", dout, 8'h00);
    step(0, 0, 2'd2, 0, 0); #2 chk("rst_mid_tma",  dout, 8'h00);
    step(0, 0, 2'd3, 0, 0); #2 chk("rst_mid_tac",  dout, 8'hF8);

    for (int i = 0; i < 4000; i++) begin
      bit r, c, w;
      logic [1:0] s;
      logic [7:0] d;
      r = ($urandom_range(0, 599) == 0);
      c = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 11) == 0);
      s = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      if (w && s == 2'd1 && $urandom_range(0, 1) == 1) d = 8'hFF - 8'($urandom_range(0, 2));
      if (w && s == 2'd3 && $urandom_range(0, 3) != 0) d = 8'h04 | 8'($urandom_range(0, 3));
      if (w && s == 2'd0 && $urandom_range(0, 3) != 0) w = 1'b0;
      step(r, c, s, w, d);
    end

    #2 chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
